// File: rtl/dwt_feature_framer.sv
// Per-level absolute-sum energy framer for the D1..D4 DWT coefficient streams.
// Each window of WIN_LEN D1 samples closes into four features, sent serially over valid/ready.
module dwt_feature_framer #(
  parameter int unsigned WIN_LEN = 256,
  parameter int unsigned ACC_W   = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [3:0]          d_valid,
  input  logic signed [15:0]  D1,
  input  logic signed [15:0]  D2,
  input  logic signed [15:0]  D3,
  input  logic signed [15:0]  D4,
  output logic [ACC_W-1:0]    feat_data,
  output logic [1:0]          feat_level,
  output logic                feat_valid,
  input  logic                feat_ready,
  output logic                feat_last,
  output logic                overrun
);

  localparam int unsigned CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    win_cnt;
  logic [ACC_W-1:0]    acc     [4];
  logic [ACC_W-1:0]    snap    [4];
  logic [ACC_W-1:0]    acc_nxt [4];
  logic [ACC_W:0]      sum     [4];
  logic [15:0]         mag     [4];
  logic signed [15:0]  din     [4];
  logic                close;

  assign din[0] = D1;
  assign din[1] = D2;
  assign din[2] = D3;
  assign din[3] = D4;

  assign close = clk_enable && d_valid[0] && (win_cnt == CNT_W'(WIN_LEN - 1));

  // Next accumulator value includes this cycle's sample, so the snapshot taken
  // at close already contains the closing D1 and any coincident D2..D4 samples.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (din[k] == 16'sh8000)
        mag[k] = 16'h7fff;
      else if (din[k][15])
        mag[k] = 16'(-din[k]);
      else
        mag[k] = 16'(din[k]);
      sum[k]     = {1'b0, acc[k]} + (ACC_W + 1)'(mag[k]);
      acc_nxt[k] = acc[k];
      if (clk_enable && d_valid[k])
        acc_nxt[k] = sum[k][ACC_W] ? '1 : sum[k][ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      win_cnt    <= '0;
      feat_data  <= '0;
      feat_level <= '0;
      feat_valid <= 1'b0;
      feat_last  <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        acc[k]  <= '0;
        snap[k] <= '0;
      end
    end else begin
      if (clk_enable && d_valid[0])
        win_cnt <= close ? '0 : win_cnt + 1'b1;

      for (int unsigned k = 0; k < 4; k++)
        acc[k] <= close ? '0 : acc_nxt[k];

      case (state)
        IDLE: begin
          if (close) begin
            for (int unsigned k = 0; k < 4; k++)
              snap[k] <= acc_nxt[k];
            state      <= EMIT;
            feat_valid <= 1'b1;
            feat_data  <= acc_nxt[0];
            feat_level <= 2'd0;
            feat_last  <= 1'b0;
          end
        end
        EMIT: begin
          if (close)
            overrun <= 1'b1;
          if (feat_ready) begin
            if (feat_level == 2'd3) begin
              state      <= IDLE;
              feat_valid <= 1'b0;
              feat_last  <= 1'b0;
            end else begin
              feat_data  <= snap[feat_level + 2'd1];
              feat_level <= feat_level + 2'd1;
              feat_last  <= (feat_level == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dwt_feature_framer.sv
// Bench for dwt_feature_framer: two instances (ACC_W 24 and 16) on shared stimulus,
// checked every cycle against a window/queue model, plus literal expectations.
module tb_dwt_feature_framer;

  localparam int unsigned WIN = 4;

  logic clk = 1'b0;
  logic reset, clk_enable, feat_ready;
  logic [3:0] d_valid;
  logic signed [15:0] D1, D2, D3, D4;

  logic [23:0] fd0;
  logic [15:0] fd1;
  logic [1:0]  fl0, fl1;
  logic        fv0, fv1, fla0, fla1, ov0, ov1;

  always #5 clk = ~clk;

  dwt_feature_framer #(.WIN_LEN(WIN), .ACC_W(24)) u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .d_valid(d_valid),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .feat_data(fd0), .feat_level(fl0), .feat_valid(fv0), .feat_ready(feat_ready),
    .feat_last(fla0), .overrun(ov0)
  );

  dwt_feature_framer #(.WIN_LEN(WIN), .ACC_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .d_valid(d_valid),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4),
    .feat_data(fd1), .feat_level(fl1), .feat_valid(fv1), .feat_ready(feat_ready),
    .feat_last(fla1), .overrun(ov1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_max  [2] = '{64'hFF_FFFF, 64'hFFFF};
  longint m_acc  [2][4];
  longint m_win  [2][4];
  int     m_left [2];
  bit     m_ovr  [2];
  int     m_cnt;
  bit     m_close, m_busy;
  longint m_d    [4];

  function automatic longint magnitude(input logic signed [15:0] x);
    longint v;
    v = x;
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_left[i] = 0;
        m_ovr[i]  = 0;
        for (int k = 0; k < 4; k++) begin
          m_acc[i][k] = 0;
          m_win[i][k] = 0;
        end
      end
    end else begin
      m_d[0] = magnitude(D1); m_d[1] = magnitude(D2);
      m_d[2] = magnitude(D3); m_d[3] = magnitude(D4);
      m_close = 0;
      if (clk_enable && d_valid[0]) begin
        m_cnt++;
        if (m_cnt == WIN) m_close = 1;
      end
      for (int i = 0; i < 2; i++) begin
        m_busy = (m_left[i] != 0);
        if (clk_enable)
          for (int k = 0; k < 4; k++)
            if (d_valid[k]) begin
              m_acc[i][k] += m_d[k];
              if (m_acc[i][k] > m_max[i]) m_acc[i][k] = m_max[i];
            end
        if (m_busy && feat_ready) m_left[i]--;
        if (m_close) begin
          if (m_busy) m_ovr[i] = 1;
          else begin
            for (int k = 0; k < 4; k++) m_win[i][k] = m_acc[i][k];
            m_left[i] = 4;
          end
          for (int k = 0; k < 4; k++) m_acc[i][k] = 0;
        end
      end
      if (m_close) m_cnt = 0;
    end
  end

  task automatic cmp_inst(input int i, input logic v, input longint data,
                          input int lvl, input logic last, input logic ov);
    int el;
    chk($sformatf("i%0d feat_valid", i), v, m_left[i] != 0);
    chk($sformatf("i%0d overrun", i), ov, m_ovr[i]);
    if (m_left[i] != 0) begin
      el = 4 - m_left[i];
      chk($sformatf("i%0d feat_data", i), data, m_win[i][el]);
      chk($sformatf("i%0d feat_level", i), lvl, el);
      chk($sformatf("i%0d feat_last", i), last, el == 3);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cmp_inst(0, fv0, fd0, fl0, fla0, ov0);
      cmp_inst(1, fv1, fd1, fl1, fla1, ov1);
    end
  end

  // ---------------- accepted-beat log ----------------
  typedef struct {longint data; int lvl; bit last; int cyc;} beat_t;
  beat_t log0[$];
  beat_t log1[$];
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (fv0 && feat_ready) log0.push_back('{fd0, fl0, fla0, cyc});
      if (fv1 && feat_ready) log1.push_back('{fd1, fl1, fla1, cyc});
    end
  end

  task automatic clear_logs();
    log0.delete();
    log1.delete();
  endtask

  task automatic check_win(input string tag, input int inst,
                           input longint e0, input longint e1, input longint e2, input longint e3);
    longint e[4];
    beat_t q[$];
    e = '{e0, e1, e2, e3};
    if (inst == 0) q = log0; else q = log1;
    chk($sformatf("%s i%0d beats", tag, inst), q.size(), 4);
    for (int j = 0; j < 4; j++)
      if (j < q.size()) begin
        chk($sformatf("%s i%0d word%0d data", tag, inst, j), q[j].data, e[j]);
        chk($sformatf("%s i%0d word%0d level", tag, inst, j), q[j].lvl, j);
        chk($sformatf("%s i%0d word%0d last", tag, inst, j), q[j].last, j == 3);
      end
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] dv, input int a, input int b, input int c, input int d);
    d_valid = dv;
    D1 = 16'(a); D2 = 16'(b); D3 = 16'(c); D4 = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 0, 0, 0, 0);
  endtask

  function automatic int rnd16();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b1; feat_ready = 1'b1;
    d_valid = '0; D1 = '0; D2 = '0; D3 = '0; D4 = '0;
    #12;
    chk("reset feat_valid", fv0, 0);
    chk("reset feat_data", fd0, 0);
    chk("reset feat_level", fl0, 0);
    chk("reset feat_last", fla0, 0);
    chk("reset overrun", ov0, 0);
    chk("reset i1 feat_valid", fv1, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: basic D1 window
    clear_logs();
    step(4'b0001, 100, 0, 0, 0);
    step(4'b0001, -200, 0, 0, 0);
    step(4'b0001, 300, 0, 0, 0);
    step(4'b0001, -400, 0, 0, 0);
    chk("t1 valid after close", fv0, 1);
    idle(6);
    check_win("t1", 0, 1000, 0, 0, 0);
    if (log0.size() == 4) chk("t1 consecutive beats", log0[3].cyc - log0[0].cyc, 3);

    // 2: multirate
    clear_logs();
    for (int i = 0; i < 4; i++)
      step({i == 3, i == 3, i % 2 == 1, 1'b1}, 1, -50, 7, -32768);
    idle(6);
    check_win("t2", 0, 4, 100, 7, 32767);
    check_win("t2", 1, 4, 100, 7, 32767);

    // 3: backpressure
    clear_logs();
    feat_ready = 1'b0;
    repeat (4) step(4'b0001, 10, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3 hold valid", fv0, 1);
      chk("t3 hold data", fd0, 40);
      chk("t3 hold level", fl0, 0);
      idle(1);
    end
    feat_ready = 1'b1;
    idle(6);
    check_win("t3", 0, 40, 0, 0, 0);

    // 4: overrun
    clear_logs();
    feat_ready = 1'b0;
    repeat (4) step(4'b0001, 5, 0, 0, 0);
    repeat (4) step(4'b0001, 9, 0, 0, 0);
    chk("t4 overrun", ov0, 1);
    chk("t4 i1 overrun", ov1, 1);
    feat_ready = 1'b1;
    idle(8);
    check_win("t4 first", 0, 20, 0, 0, 0);
    clear_logs();
    repeat (4) step(4'b0001, 3, 0, 0, 0);
    idle(6);
    check_win("t4 third", 0, 12, 0, 0, 0);
    chk("t4 overrun sticky", ov0, 1);

    // 5: saturation
    clear_logs();
    repeat (4) step(4'b0001, 32767, 0, 0, 0);
    idle(6);
    check_win("t5", 0, 131068, 0, 0, 0);
    check_win("t5", 1, 65535, 0, 0, 0);

    // 6: reset mid-emission
    clear_logs();
    repeat (4) step(4'b0001, 1, 0, 0, 0);
    for (int t = 0; t < 10 && log0.size() < 2; t++) idle(1);
    chk("t6 beats before reset", log0.size(), 2);
    #2 reset = 1'b1;
    #1;
    chk("t6 valid in reset", fv0, 0);
    chk("t6 i1 valid in reset", fv1, 0);
    chk("t6 overrun cleared", ov0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_logs();
    repeat (4) step(4'b0001, 2, 0, 0, 0);
    idle(6);
    check_win("t6", 0, 8, 0, 0, 0);

    // 7: clk_enable gates sampling but not emission
    clear_logs();
    clk_enable = 1'b0;
    repeat (2) step(4'b1111, 1000, 1000, 1000, 1000);
    clk_enable = 1'b1;
    repeat (3) step(4'b0001, 1, 0, 0, 0);
    step(4'b0011, 1, 6, 0, 0);
    clk_enable = 1'b0;
    idle(6);
    check_win("t7", 0, 4, 6, 0, 0);
    clk_enable = 1'b1;

    // random phase
    for (int n = 0; n < 1500; n++) begin
      clk_enable = ($urandom_range(0, 3) != 0);
      if ((n % 100) < 30) feat_ready = ($urandom_range(0, 5) == 0);
      else feat_ready = ($urandom_range(0, 3) != 0);
      if (n == 700) reset = 1'b1;
      if (n == 701) reset = 1'b0;
      step(4'($urandom), rnd16(), rnd16(), rnd16(), rnd16());
    end
    clk_enable = 1'b1;
    feat_ready = 1'b1;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
